// File: rtl/graph_note_roll.sv
`default_nettype none
// ============================================================================
// graph_note_roll : scrolling piano-roll note store with raster pixel read-out
// Optional feature macro: GRAPH_NOTE_ROLL_GRID_EN (cell-boundary grid pixels)
// Revision: 1.0 - initial release
// ============================================================================
module graph_note_roll #(
    parameter int COLS   = 64,
    parameter int ROWS   = 32,
    parameter int CELL_W = 10,
    parameter int CELL_H = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ev_valid_i,
    output logic                    ev_ready_o,
    input  logic [$clog2(ROWS)-1:0] ev_row_i,
    input  logic [2:0]              ev_inst_i,
    input  logic                    tick_i,
    output logic                    overrun_o,
    input  logic                    frame_start_i,
    input  logic                    line_start_i,
    input  logic                    pix_en_i,
    output logic                    pix_valid_o,
    output logic                    pix_hit_o,
    output logic [2:0]              pix_inst_o,
    output logic                    pix_grid_o
);

    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int AW  = CW + RW;
    localparam int SXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int SYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            pend_q, pend_d;
    logic            overrun_q, overrun_d;

    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [3:0]      w_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        pend_d     = pend_q;
        overrun_d  = overrun_q;
        w_we       = 1'b0;
        w_waddr    = {wr_ptr_q, cnt_q[RW-1:0]};
        w_wdata    = 4'd0;
        ev_ready_o = 1'b0;
        case (state_q)
            ST_INIT: begin
                w_we    = 1'b1;
                w_waddr = cnt_q;
                cnt_d   = cnt_q + AW'(1);
                if (tick_i) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q == AW'(COLS * ROWS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ev_ready_o = 1'b1;
                if (ev_valid_i) begin
                    w_we    = 1'b1;
                    w_waddr = {wr_ptr_q, ev_row_i};
                    w_wdata = {1'b1, ev_inst_i};
                end
                if (tick_i) begin
                    wr_ptr_d = wr_ptr_q + CW'(1);
                    cnt_d    = '0;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_we  = 1'b1;
                cnt_d = cnt_q + AW'(1);
                if (tick_i) begin
                    if (pend_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
                if (cnt_q[RW-1:0] == RW'(ROWS - 1)) begin
                    cnt_d = '0;
                    // A tick landing on the final clear cycle is served like a pending one.
                    if (pend_q || tick_i) begin
                        wr_ptr_d = wr_ptr_q + CW'(1);
                        pend_d   = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign overrun_o = overrun_q;

    // ------------------------------------------------------------------
    // Raster position tracking
    // ------------------------------------------------------------------
    logic [CW-1:0]   base_q;
    logic [CW:0]     cell_x_q;
    logic [RW:0]     cell_y_q;
    logic [SXW-1:0]  sub_x_q;
    logic [SYW-1:0]  sub_y_q;
    logic            first_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            cell_x_q <= '0;
            cell_y_q <= '0;
            sub_x_q  <= '0;
            sub_y_q  <= '0;
            first_q  <= 1'b0;
        end else begin
            if (frame_start_i) begin
                base_q   <= wr_ptr_q;
                cell_y_q <= '0;
                sub_y_q  <= '0;
                first_q  <= ~line_start_i;
            end else if (line_start_i) begin
                if (first_q) begin
                    first_q <= 1'b0;
                end else if (sub_y_q == SYW'(CELL_H - 1)) begin
                    sub_y_q <= '0;
                    if (!cell_y_q[RW]) begin
                        cell_y_q <= cell_y_q + (RW+1)'(1);
                    end
                end else begin
                    sub_y_q <= sub_y_q + SYW'(1);
                end
            end
            if (line_start_i) begin
                cell_x_q <= '0;
                sub_x_q  <= '0;
            end else if (pix_en_i) begin
                if (sub_x_q == SXW'(CELL_W - 1)) begin
                    sub_x_q <= '0;
                    // Saturate once past the last column so the pixel stays out of range.
                    if (!cell_x_q[CW]) begin
                        cell_x_q <= cell_x_q + (CW+1)'(1);
                    end
                end else begin
                    sub_x_q <= sub_x_q + SXW'(1);
                end
            end
        end
    end

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [AW-1:0] w_raddr;
    logic          w_inrange;

    assign w_col     = base_q + CW'(1) + cell_x_q[CW-1:0];
    assign w_row     = ~cell_y_q[RW-1:0];
    assign w_raddr   = {w_col, w_row};
    assign w_inrange = ~cell_x_q[CW] & ~cell_y_q[RW];

    // ------------------------------------------------------------------
    // Storage: one write port, one registered read port (read-old on collision)
    // ------------------------------------------------------------------
    logic [3:0] mem_q [COLS*ROWS];
    logic [3:0] rd_q;

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[w_waddr] <= w_wdata;
        end
        rd_q <= mem_q[w_raddr];
    end

    // ------------------------------------------------------------------
    // Two-stage pixel pipeline
    // ------------------------------------------------------------------
    logic       v1_q;
    logic       inr1_q;
    logic       w_show;
    logic       pix_valid_q;
    logic       pix_hit_q;
    logic [2:0] pix_inst_q;

`ifdef GRAPH_NOTE_ROLL_GRID_EN
    logic w_grid;
    logic grid1_q;
    logic pix_grid_q;

    assign w_grid = w_inrange & ((sub_x_q == '0) | (sub_y_q == '0));
    assign w_show = v1_q & inr1_q & ~grid1_q & rd_q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid1_q    <= 1'b0;
            pix_grid_q <= 1'b0;
        end else begin
            grid1_q    <= w_grid;
            pix_grid_q <= v1_q & grid1_q;
        end
    end

    assign pix_grid_o = pix_grid_q;
`else
    assign w_show     = v1_q & inr1_q & rd_q[3];
    assign pix_grid_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            inr1_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_hit_q   <= 1'b0;
            pix_inst_q  <= 3'd0;
        end else begin
            v1_q        <= pix_en_i;
            inr1_q      <= w_inrange;
            pix_valid_q <= v1_q;
            pix_hit_q   <= w_show;
            pix_inst_q  <= w_show ? rd_q[2:0] : 3'd0;
        end
    end

    assign pix_valid_o = pix_valid_q;
    assign pix_hit_o   = pix_hit_q;
    assign pix_inst_o  = pix_inst_q;

endmodule
`default_nettype wire

// File: tb/tb_graph_note_roll.sv
`default_nettype none
// ============================================================================
// tb_graph_note_roll : scoreboard bench for the piano-roll note store
// Revision: 1.0 - initial release
// ============================================================================
module tb_graph_note_roll;

    localparam int COLS   = 64;
    localparam int ROWS   = 32;
    localparam int CELL_W = 10;
    localparam int CELL_H = 15;
    localparam int RW     = 5;
    localparam int XMAX   = 650;
    localparam int YMAX   = 482;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic [RW-1:0] ev_row = '0;
    logic [2:0]    ev_inst = 3'd0;
    logic          tick = 1'b0;
    logic          overrun;
    logic          frame_start = 1'b0;
    logic          line_start = 1'b0;
    logic          pix_en = 1'b0;
    logic          pix_valid;
    logic          pix_hit;
    logic [2:0]    pix_inst;
    logic          pix_grid;

    graph_note_roll #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .CELL_W (CELL_W),
        .CELL_H (CELL_H)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ev_valid_i    (ev_valid),
        .ev_ready_o    (ev_ready),
        .ev_row_i      (ev_row),
        .ev_inst_i     (ev_inst),
        .tick_i        (tick),
        .overrun_o     (overrun),
        .frame_start_i (frame_start),
        .line_start_i  (line_start),
        .pix_en_i      (pix_en),
        .pix_valid_o   (pix_valid),
        .pix_hit_o     (pix_hit),
        .pix_inst_o    (pix_inst),
        .pix_grid_o    (pix_grid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] val;
        int         t;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    logic [3:0] model [COLS*ROWS];
    int         m_wptr = 0;
    logic       mon_en = 1'b0;
    int         scan_y [9] = '{0, 1, 14, 15, 315, 329, 465, 479, 480};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < COLS*ROWS; i++) model[i] = 4'd0;
        m_wptr = 0;
    endtask

    task automatic model_tick();
        m_wptr = (m_wptr + 1) % COLS;
        for (int r = 0; r < ROWS; r++) model[m_wptr*ROWS + r] = 4'd0;
    endtask

    function automatic logic [4:0] exp_pix(input int x, input int y, input int base);
        int         cx, cy, col, row;
        logic [3:0] e;
        cx = x / CELL_W;
        cy = y / CELL_H;
        if (cx >= COLS || cy >= ROWS) return 5'd0;
`ifdef GRAPH_NOTE_ROLL_GRID_EN
        if ((x % CELL_W) == 0 || (y % CELL_H) == 0) return 5'b0_000_1;
`endif
        col = (base + 1 + cx) % COLS;
        row = ROWS - 1 - cy;
        e   = model[col*ROWS + row];
        return e[3] ? {1'b1, e[2:0], 1'b0} : 5'd0;
    endfunction

    function automatic bit in_scan(input int y);
        foreach (scan_y[i]) if (scan_y[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    // Pixel monitor: every valid output is matched against the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pix_valid) begin
                if (sbq.size() == 0) begin
                    check_eq("pix_unexpected", 32'(pix_valid), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check_eq("pix_latency", 32'(cyc), 32'(mon_e.t));
                    check_eq("pix_data", {27'd0, pix_hit, pix_inst, pix_grid}, {27'd0, mon_e.val});
                end
            end else begin
                check_eq("pix_idle", {28'd0, pix_hit, pix_inst, pix_grid}, 32'd0);
            end
        end
    end

    task automatic wait_ready(input int t1, input int t2, output int n);
        n = 0;
        while (!ev_ready && n < 4000) begin
            tick = (n == t1) || (n == t2);
            step();
            tick = 1'b0;
            n++;
        end
        if (!ev_ready) check_eq("ready_timeout", 32'(ev_ready), 32'd1);
    endtask

    task automatic send_event(input int row, input int inst, input bit with_tick);
        int n;
        wait_ready(-1, -1, n);
        ev_valid = 1'b1;
        ev_row   = RW'(row);
        ev_inst  = 3'(inst);
        tick     = with_tick;
        model[m_wptr*ROWS + row] = {1'b1, 3'(inst)};
        if (with_tick) model_tick();
        step();
        ev_valid = 1'b0;
        tick     = 1'b0;
    endtask

    task automatic scan_frame(input int tick_at_y);
        int base;
        base = m_wptr;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int y = 0; y < YMAX; y++) begin
            line_start = 1'b1;
            if (y == tick_at_y) begin
                tick = 1'b1;
                model_tick();
            end
            step();
            line_start = 1'b0;
            tick       = 1'b0;
            if (in_scan(y)) begin
                for (int x = 0; x < XMAX; x++) begin
                    pix_en = 1'b1;
                    sbq.push_back('{val: exp_pix(x, y, base), t: cyc + 2});
                    step();
                end
                pix_en = 1'b0;
            end
        end
        repeat (4) step();
        check_eq("sb_drained", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int n;
        model_clear();
        repeat (3) step();
        check_eq("rst_ev_ready", 32'(ev_ready), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        check_eq("rst_pix", {28'd0, pix_valid, pix_hit, pix_inst, pix_grid}, 32'd0);

        rst_n  = 1'b1;
        mon_en = 1'b1;
        wait_ready(-1, -1, n);
        check_eq("init_cycles", 32'(n), 32'(COLS*ROWS));
        check_eq("overrun_idle", 32'(overrun), 32'd0);
        scan_frame(-1);

        // Highest pitch in the column being written: top-right cell.
        send_event(31, 5, 1'b0);
        scan_frame(-1);

        send_event(0, 2, 1'b0);
        tick = 1'b1;
        model_tick();
        step();
        tick = 1'b0;
        check_eq("clear_ready_low", 32'(ev_ready), 32'd0);
        wait_ready(-1, -1, n);
        check_eq("clear_cycles", 32'(n), 32'(ROWS));
        scan_frame(-1);

        // Event and tick together, then one pending and one dropped tick.
        send_event(10, 3, 1'b1);
        wait_ready(2, 5, n);
        model_tick();
        check_eq("double_clear_cycles", 32'(n), 32'(2*ROWS));
        check_eq("overrun_set", 32'(overrun), 32'd1);
        scan_frame(-1);

        // A tick mid-frame must not shift this frame, only the next one.
        scan_frame(300);
        wait_ready(-1, -1, n);
        scan_frame(-1);

        // Reset in the middle of a column clear, with a tick during INIT.
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_eq("rst2_ev_ready", 32'(ev_ready), 32'd0);
        check_eq("rst2_overrun", 32'(overrun), 32'd0);
        check_eq("rst2_pix_valid", 32'(pix_valid), 32'd0);
        step();
        rst_n = 1'b1;
        model_clear();
        wait_ready(100, -1, n);
        check_eq("init2_cycles", 32'(n), 32'(COLS*ROWS));
        check_eq("overrun_init_tick", 32'(overrun), 32'd1);
        send_event(31, 7, 1'b0);
        scan_frame(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
